// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: FSM states, decoded operations and the default width.
package counter_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        INC1,
        INC2,
        HALT
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_HALT,
        OP_CLR,
        OP_JUMP,
        OP_SKIP,
        OP_STEP
    } op_e;

endpackage

// File: rtl/counter_sequencer_if.sv
// Request and counter-control bundle between decode logic, the sequencer and the counter.
interface counter_sequencer_if #(parameter int WIDTH = 8);

    logic             clear_req;
    logic             jump_req;
    logic [WIDTH-1:0] jump_addr;
    logic             skip_req;
    logic             step_req;
    logic             halt_req;
    logic             resume;
    logic [WIDTH-1:0] cnt_q;
    logic             cnt_reset;
    logic             cnt_load;
    logic             cnt_ce;
    logic [WIDTH-1:0] cnt_preset;
    logic             busy;
    logic             done;
    logic             halted;

    // Control path and counter side: issues requests, supplies the counter value.
    modport master (
        output clear_req, jump_req, jump_addr, skip_req, step_req, halt_req, resume, cnt_q,
        input  cnt_reset, cnt_load, cnt_ce, cnt_preset, busy, done, halted
    );

    modport slave (
        input  clear_req, jump_req, jump_addr, skip_req, step_req, halt_req, resume, cnt_q,
        output cnt_reset, cnt_load, cnt_ce, cnt_preset, busy, done, halted
    );

endinterface

// File: rtl/counter_seq_prio.sv
// Fixed-priority request encoder: halt > clear > jump > skip > step.
module counter_seq_prio
    import counter_seq_pkg::*;
(
    input  logic halt_req,
    input  logic clear_req,
    input  logic jump_req,
    input  logic skip_req,
    input  logic step_req,
    output op_e  op
);

    always_comb begin
        op = OP_NONE;
        if (halt_req)       op = OP_HALT;
        else if (clear_req) op = OP_CLR;
        else if (jump_req)  op = OP_JUMP;
        else if (skip_req)  op = OP_SKIP;
        else if (step_req)  op = OP_STEP;
    end

endmodule

// File: rtl/counter_sequencer.sv
// Sequences reset/load/count-enable of an up-counter from single-cycle requests, with halt/resume.
// Optional wrap trap (halt after an increment from all ones) enabled by COUNTER_SEQUENCER_WRAP_TRAP_EN.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    counter_sequencer_if.slave   bus
`ifdef COUNTER_SEQUENCER_WRAP_TRAP_EN
    ,
    output logic                 wrap_trap
`endif
);

    state_e           state;
    op_e              op;
    logic             skip_flag;
    logic             halt_pend;
    logic             cnt_reset;
    logic             cnt_load;
    logic             cnt_ce;
    logic [WIDTH-1:0] cnt_preset;
    logic             busy;
    logic             done;
    logic             halted;
`ifdef COUNTER_SEQUENCER_WRAP_TRAP_EN
    logic             wrap_flag;
`endif

    counter_seq_prio u_prio (
        .halt_req  (bus.halt_req),
        .clear_req (bus.clear_req),
        .jump_req  (bus.jump_req),
        .skip_req  (bus.skip_req),
        .step_req  (bus.step_req),
        .op        (op)
    );

    // Outputs are loaded with the values belonging to the state being entered.
    // A halt seen mid-operation (or a wrap) is parked in halt_pend and taken
    // from the IDLE cycle that carries the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            skip_flag  <= 1'b0;
            halt_pend  <= 1'b0;
            cnt_reset  <= 1'b1;
            cnt_load   <= 1'b0;
            cnt_ce     <= 1'b0;
            cnt_preset <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            halted     <= 1'b0;
`ifdef COUNTER_SEQUENCER_WRAP_TRAP_EN
            wrap_flag  <= 1'b0;
            wrap_trap  <= 1'b0;
`endif
        end else begin
            cnt_reset <= 1'b0;
            cnt_load  <= 1'b0;
            cnt_ce    <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (halt_pend) begin
                        state     <= HALT;
                        halted    <= 1'b1;
                        halt_pend <= 1'b0;
`ifdef COUNTER_SEQUENCER_WRAP_TRAP_EN
                        wrap_trap <= wrap_flag;
                        wrap_flag <= 1'b0;
`endif
                    end else begin
                        case (op)
                            OP_HALT: begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end
                            OP_CLR: begin
                                state     <= CLR;
                                cnt_reset <= 1'b1;
                                busy      <= 1'b1;
                            end
                            OP_JUMP: begin
                                state      <= LOAD;
                                cnt_load   <= 1'b1;
                                cnt_preset <= bus.jump_addr;
                                busy       <= 1'b1;
                            end
                            OP_SKIP: begin
                                state     <= INC1;
                                cnt_ce    <= 1'b1;
                                skip_flag <= 1'b1;
                                busy      <= 1'b1;
                            end
                            OP_STEP: begin
                                state     <= INC1;
                                cnt_ce    <= 1'b1;
                                skip_flag <= 1'b0;
                                busy      <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                CLR, LOAD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (bus.halt_req) halt_pend <= 1'b1;
                end
                INC1, INC2: begin
                    if (bus.halt_req) halt_pend <= 1'b1;
`ifdef COUNTER_SEQUENCER_WRAP_TRAP_EN
                    if (&bus.cnt_q) begin
                        wrap_flag <= 1'b1;
                        halt_pend <= 1'b1;
                    end
`endif
                    if (state == INC1 && skip_flag) begin
                        state  <= INC2;
                        cnt_ce <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                HALT: begin
                    if (bus.resume) begin
                        state  <= IDLE;
                        halted <= 1'b0;
`ifdef COUNTER_SEQUENCER_WRAP_TRAP_EN
                        wrap_trap <= 1'b0;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cnt_reset  = cnt_reset;
    assign bus.cnt_load   = cnt_load;
    assign bus.cnt_ce     = cnt_ce;
    assign bus.cnt_preset = cnt_preset;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.halted     = halted;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a behavioural up-counter closes the loop, table vectors plus corner sequences.
module tb_counter_sequencer;

    localparam int WIDTH = 8;

    logic clk;
    logic reset_n;
`ifdef COUNTER_SEQUENCER_WRAP_TRAP_EN
    logic wrap_trap;
`endif

    counter_sequencer_if #(.WIDTH(WIDTH)) bus ();

    counter_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus)
`ifdef COUNTER_SEQUENCER_WRAP_TRAP_EN
        ,
        .wrap_trap (wrap_trap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-load, async-reset up-counter driven by the sequencer.
    always_ff @(posedge clk or posedge bus.cnt_reset) begin
        if (bus.cnt_reset)     bus.cnt_q <= '0;
        else if (bus.cnt_load) bus.cnt_q <= bus.cnt_preset;
        else if (bus.cnt_ce)   bus.cnt_q <= bus.cnt_q + 1'b1;
    end

    // req bits: {halt, clear, jump, skip, step}
    typedef struct {
        string      name;
        logic [4:0] req;
        logic [7:0] addr;
        logic [7:0] exp_q;
        int         exp_done_at;
        int         exp_dones;
        int         exp_busy;
        int         exp_ce;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   passed;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic clearReqs();
        bus.halt_req  = 1'b0;
        bus.clear_req = 1'b0;
        bus.jump_req  = 1'b0;
        bus.skip_req  = 1'b0;
        bus.step_req  = 1'b0;
    endtask

    // One request pulse from IDLE, then six observations, one per edge.
    task automatic applyStimulus(input vec_t v);
        int done_at, dones, busy_n, ce_n;
        done_at = 0; dones = 0; busy_n = 0; ce_n = 0;
        @(negedge clk);
        {bus.halt_req, bus.clear_req, bus.jump_req, bus.skip_req, bus.step_req} = v.req;
        bus.jump_addr = v.addr;
        @(posedge clk);
        #1 clearReqs();
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (done_at == 0) done_at = k;
            end
            if (bus.busy)   busy_n++;
            if (bus.cnt_ce) ce_n++;
        end
        checkOutput({v.name, " q"},       bus.cnt_q, v.exp_q);
        checkOutput({v.name, " done_at"}, done_at,   v.exp_done_at);
        checkOutput({v.name, " dones"},   dones,     v.exp_dones);
        checkOutput({v.name, " busy"},    busy_n,    v.exp_busy);
        checkOutput({v.name, " ce"},      ce_n,      v.exp_ce);
    endtask

    task automatic pulseResume();
        @(negedge clk);
        bus.resume = 1'b1;
        @(posedge clk);
        #1 bus.resume = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int dones;
        total = 0;
        passed = 0;
        clearReqs();
        bus.resume    = 1'b0;
        bus.jump_addr = '0;
        reset_n       = 1'b0;

        vecs.push_back('{"step",        5'b00001, 8'h00, 8'h01, 2, 1, 1, 1});
        vecs.push_back('{"jump_vs_skip", 5'b00110, 8'hA5, 8'hA5, 2, 1, 1, 0});
        vecs.push_back('{"jump10",      5'b00100, 8'h10, 8'h10, 2, 1, 1, 0});
        vecs.push_back('{"skip",        5'b00010, 8'h00, 8'h12, 3, 1, 2, 2});
        vecs.push_back('{"clear_prio",  5'b01101, 8'h44, 8'h00, 2, 1, 1, 0});
        vecs.push_back('{"skip_vs_step", 5'b00011, 8'h00, 8'h02, 3, 1, 2, 2});
        vecs.push_back('{"jumpFE",      5'b00100, 8'hFE, 8'hFE, 2, 1, 1, 0});
`ifndef COUNTER_SEQUENCER_WRAP_TRAP_EN
        vecs.push_back('{"skip_wrap",   5'b00010, 8'h00, 8'h00, 3, 1, 2, 2});
        vecs.push_back('{"idle_none",   5'b00000, 8'h00, 8'h00, 0, 0, 0, 0});
`else
        vecs.push_back('{"idle_none",   5'b00000, 8'h00, 8'hFE, 0, 0, 0, 0});
`endif

        #12;
        checkOutput("rst cnt_reset",  bus.cnt_reset,  1);
        checkOutput("rst cnt_load",   bus.cnt_load,   0);
        checkOutput("rst cnt_ce",     bus.cnt_ce,     0);
        checkOutput("rst cnt_preset", bus.cnt_preset, 0);
        checkOutput("rst busy_done_halted", {bus.busy, bus.done, bus.halted}, 0);
        checkOutput("rst q",          bus.cnt_q,      0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("rst release cnt_reset", bus.cnt_reset, 0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        $display("[TB] halt during INC2 of a skip");
        applyStimulus('{"jump30", 5'b00100, 8'h30, 8'h30, 2, 1, 1, 0});
        @(negedge clk);
        bus.skip_req = 1'b1;
        @(posedge clk);
        #1 bus.skip_req = 1'b0;
        @(posedge clk);
        #1 bus.halt_req = 1'b1;
        @(posedge clk);
        #1 bus.halt_req = 1'b0;
        @(negedge clk);
        checkOutput("halt_inc2 done",   bus.done,   1);
        checkOutput("halt_inc2 halted", bus.halted, 0);
        checkOutput("halt_inc2 q",      bus.cnt_q,  8'h32);
        @(negedge clk);
        checkOutput("halt_inc2 halted later", bus.halted, 1);
        checkOutput("halt_inc2 done later",   bus.done,   0);
        @(negedge clk);
        bus.step_req = 1'b1;
        bus.halt_req = 1'b1;
        @(posedge clk);
        #1 clearReqs();
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checkOutput("halted step q",     bus.cnt_q,  8'h32);
        checkOutput("halted step dones", dones,      0);
        checkOutput("halted still",      bus.halted, 1);
        pulseResume();
        checkOutput("resume halted", bus.halted, 0);
        applyStimulus('{"step_after_resume", 5'b00001, 8'h00, 8'h33, 2, 1, 1, 1});

        $display("[TB] halt beats clear in IDLE");
        @(negedge clk);
        bus.halt_req  = 1'b1;
        bus.clear_req = 1'b1;
        @(posedge clk);
        #1 clearReqs();
        @(negedge clk);
        checkOutput("halt_vs_clear halted", bus.halted, 1);
        checkOutput("halt_vs_clear q",      bus.cnt_q,  8'h33);
        pulseResume();

        $display("[TB] reset during LOAD");
        @(negedge clk);
        bus.jump_req  = 1'b1;
        bus.jump_addr = 8'h77;
        @(posedge clk);
        #1 bus.jump_req = 1'b0;
        checkOutput("load cnt_load", bus.cnt_load, 1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midrst cnt_reset",  bus.cnt_reset,  1);
        checkOutput("midrst cnt_load",   bus.cnt_load,   0);
        checkOutput("midrst cnt_preset", bus.cnt_preset, 0);
        checkOutput("midrst busy_done",  {bus.busy, bus.done}, 0);
        checkOutput("midrst q",          bus.cnt_q,      0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checkOutput("midrst dones", dones,     0);
        checkOutput("midrst q after", bus.cnt_q, 0);
        applyStimulus('{"step_after_rst", 5'b00001, 8'h00, 8'h01, 2, 1, 1, 1});

`ifdef COUNTER_SEQUENCER_WRAP_TRAP_EN
        $display("[TB] wrap trap");
        applyStimulus('{"jumpFF", 5'b00100, 8'hFF, 8'hFF, 2, 1, 1, 0});
        @(negedge clk);
        bus.step_req = 1'b1;
        @(posedge clk);
        #1 bus.step_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("wrap q",      bus.cnt_q,  8'h00);
        checkOutput("wrap done",   bus.done,   1);
        @(negedge clk);
        checkOutput("wrap halted", bus.halted, 1);
        checkOutput("wrap trap",   wrap_trap,  1);
        pulseResume();
        checkOutput("wrap resume halted", bus.halted, 0);
        checkOutput("wrap resume trap",   wrap_trap,  0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that sequences one sync-load, async-reset up-counter (MC10E016-style, e.g. the program counter) by driving its reset/load/preset/ce pins.
- Accepts single-cycle operation requests (clear, jump, skip, step) from the control path, arbitrates them by fixed priority, runs each as a short FSM sequence, and reports completion.
- Supports halt/resume.
- Sits between instruction-decode control logic and the counter instance.

Parameters:
- WIDTH, 8, counter width; also the width of jump_addr, cnt_preset and cnt_q.

Ports:
- clk  in  1  single system clock
- reset_n  in  1  asynchronous, active-low reset
- clear_req  in  1  request: zero the counter
- jump_req  in  1  request: load jump_addr
- jump_addr  in  WIDTH  jump target, sampled with jump_req
- skip_req  in  1  request: advance counter by 2
- step_req  in  1  request: advance counter by 1
- halt_req  in  1  request: enter HALT
- resume  in  1  leave HALT
- cnt_q  in  WIDTH  counter output, fed back
- cnt_reset  out  1  to counter reset (active-high)
- cnt_load  out  1  to counter load
- cnt_ce  out  1  to counter count enable
- cnt_preset  out  WIDTH  to counter preset
- busy  out  1  FSM not in IDLE or HALT
- done  out  1  one-cycle pulse: operation finished
- halted  out  1  FSM in HALT

Behaviour:
- All outputs are registered. Clock and reset polarity and synchronicity are fixed as listed in Ports.
- Reset (reset_n low, async):
  - state=IDLE.
  - cnt_reset=1, so the counter is held cleared during reset.
  - cnt_load=0, cnt_ce=0, cnt_preset=0, busy=0, done=0, halted=0.
  - cnt_reset drops at the first clk edge after reset_n rises.
- States: IDLE, CLR, LOAD, INC1, INC2, HALT.
- IDLE: requests are sampled on each edge. Priority is halt_req > clear_req > jump_req > skip_req > step_req. Lower-priority requests in the same cycle are dropped, not queued.
  - halt_req -> HALT.
  - clear_req -> CLR.
  - jump_req -> LOAD; cnt_preset <= jump_addr.
  - skip_req -> INC1, with a skip flag set.
  - step_req -> INC1.
- CLR: cnt_reset=1 for exactly one cycle, then -> IDLE.
- LOAD: cnt_load=1 for exactly one cycle, then -> IDLE. cnt_preset holds its value until the next jump.
- INC1: cnt_ce=1 for one cycle. If the skip flag is set -> INC2, else -> IDLE.
- INC2: cnt_ce=1 for one cycle, then -> IDLE.
- Completion:
  - done=1 for one cycle in the IDLE cycle immediately after the last op state.
  - Latency from request edge to done: step/clear/jump = 2 cycles, skip = 3 cycles.
- busy=1 in CLR/LOAD/INC1/INC2. Requests arriving while busy or halted are ignored (dropped).
- halt_req during an op state: the op completes and done pulses. The FSM then enters HALT on the following edge; it does not return to IDLE-accept.
- HALT: halted=1; all cnt_* controls are 0. resume -> IDLE. halt_req while already halted has no effect.
- Wrap: counter arithmetic is modulo 2^WIDTH; the sequencer does not alter it (see Optional Feature).
- reset_n asserted mid-operation: immediate IDLE with reset values. The counter is cleared via cnt_reset, and no done is generated.

Optional Feature:
- Macro: COUNTER_SEQUENCER_WRAP_TRAP_EN.
- Defined:
  - In INC1 or INC2, if cnt_q is all ones while cnt_ce=1, set a sticky wrap flag.
  - After the op completes (done pulse), go to HALT instead of IDLE.
  - An added output wrap_trap (1 bit) is high while HALT was entered by a wrap. It clears on resume or reset.
  - For a skip whose first increment wraps, INC2 still executes before the trap.
- Undefined: no wrap_trap port; wrap is silent, modulo 2^WIDTH.

Decomposition:
- Shared package counter_seq_pkg:
  - state enum (IDLE, CLR, LOAD, INC1, INC2, HALT)
  - op enum (OP_NONE, OP_HALT, OP_CLR, OP_JUMP, OP_SKIP, OP_STEP)
  - default WIDTH constant
- One sub-module: counter_seq_prio, a combinational fixed-priority encoder from the request inputs to an op enum. Used by the FSM only in IDLE.

Test Plan:
- Reset release, then step_req pulse (counter at 0): counter=1 after 2 edges; done pulses once; busy high for 1 cycle.
- jump_req with jump_addr=8'hA5 and skip_req in the same cycle: jump wins; counter=8'hA5; skip is dropped; no second done.
- skip_req from counter=8'h10: cnt_ce high for 2 consecutive cycles; counter=8'h12; done 3 cycles after the request.
- halt_req during INC2 of a skip: skip completes to +2, done pulses, then halted=1. A step_req while halted leaves the counter unchanged. resume returns to IDLE.
- reset_n pulsed low during LOAD: outputs go to reset values immediately, counter=0, no done; normal ops work after release.
- COUNTER_SEQUENCER_WRAP_TRAP_EN defined, counter=8'hFF, step_req: counter=8'h00, done, then halted=1 and wrap_trap=1. resume clears both.
